mod_det: RTL and testbench

MOD_DET -- requirements
Module: mod_det

---
 rtl/mod_det.sv | 199 +++++++++++++++++++
 tb/tb_mod_det.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_det.sv
`default_nettype none
// ============================================================================
// Module : mod_det
// Brief  : Sequential signed 2x2 / 3x3 determinant of 8-bit elements, one micro-step per cycle
//          on a shared 8x8 multiplier and 8-bit add/sub; result wraps to 8 bits.
// Rev    : 1.0
// ============================================================================
module mod_det (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        tamanho,
  input  logic [71:0] matriz_in,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resultado,
  output logic        flag_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [71:0] mat_q, mat_d;
  logic        size_q, size_d;
  logic [1:0]  k_q, k_d;
  logic [2:0]  phase_q, phase_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  minor_q, minor_d;
  logic [7:0]  t_q, t_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  res_q, res_d;
  logic        ovf_q, ovf_d;

  logic signed [7:0] m00, m01, m02, m10, m11, m12, m20, m21, m22;

  assign m00 = mat_q[7:0];
  assign m01 = mat_q[15:8];
  assign m02 = mat_q[23:16];
  assign m10 = mat_q[31:24];
  assign m11 = mat_q[39:32];
  assign m12 = mat_q[47:40];
  assign m20 = mat_q[55:48];
  assign m21 = mat_q[63:56];
  assign m22 = mat_q[71:64];

  // Minor operands (a*d - b*c) and the row-0 cofactor element; 2x2 mode reuses the k=0 slots.
  logic signed [7:0] op_a, op_b, op_c, op_d, row0;

  always_comb begin
    op_a = m00;
    op_d = m11;
    op_b = m01;
    op_c = m10;
    row0 = m00;
    if (size_q) begin
      case (k_q)
        2'd0:    begin op_a = m11; op_d = m22; op_b = m12; op_c = m21; row0 = m00; end
        2'd1:    begin op_a = m10; op_d = m22; op_b = m12; op_c = m20; row0 = m01; end
        default: begin op_a = m10; op_d = m21; op_b = m11; op_c = m20; row0 = m02; end
      endcase
    end
  end

  logic signed [7:0]  mul_a, mul_b;
  logic signed [15:0] prod;
  logic               prod_ovf;
  logic [7:0]         add_a, add_b, add_b_eff, sum;
  logic               add_sub, add_ovf;
  logic               is_last;

  always_comb begin
    mul_a   = op_a;
    mul_b   = op_d;
    add_a   = x_q;
    add_b   = y_q;
    add_sub = 1'b1;
    case (phase_q)
      3'd1:    begin mul_a = op_b; mul_b = op_c; end
      3'd3:    begin mul_a = row0; mul_b = minor_q; end
      3'd4:    begin add_a = acc_q; add_b = t_q; add_sub = (k_q == 2'd1); end
      default: ;
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign prod_ovf = (prod > 16'sd127) || (prod < -16'sd128);

  // Subtraction as a + ~b + 1, so overflow is the usual same-sign-in / different-sign-out test.
  assign add_b_eff = add_sub ? ~add_b : add_b;
  assign sum       = add_a + add_b_eff + {7'd0, add_sub};
  assign add_ovf   = (add_a[7] == add_b_eff[7]) && (sum[7] != add_a[7]);

  assign is_last = size_q ? ((k_q == 2'd2) && (phase_q == 3'd4)) : (phase_q == 3'd2);

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    size_d  = size_q;
    k_d     = k_q;
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    minor_d = minor_q;
    t_d     = t_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
          mat_d   = matriz_in;
          size_d  = tamanho;
          k_d     = 2'd0;
          phase_d = 3'd0;
          x_d     = 8'd0;
          y_d     = 8'd0;
          minor_d = 8'd0;
          t_d     = 8'd0;
          acc_d   = 8'd0;
          ovf_d   = 1'b0;
        end
      end
      ST_CALC: begin
        case (phase_q)
          3'd0: begin x_d = prod[7:0]; ovf_d = ovf_q | prod_ovf; end
          3'd1: begin y_d = prod[7:0]; ovf_d = ovf_q | prod_ovf; end
          3'd2: begin
            ovf_d = ovf_q | add_ovf;
            if (size_q) begin
              minor_d = sum;
            end else begin
              acc_d = sum;
              res_d = sum;
            end
          end
          3'd3: begin t_d = prod[7:0]; ovf_d = ovf_q | prod_ovf; end
          default: begin
            acc_d = sum;
            ovf_d = ovf_q | add_ovf;
            if (is_last) res_d = sum;
          end
        endcase
        if (is_last) begin
          state_d = ST_DONE;
        end else if (size_q && (phase_q == 3'd4)) begin
          phase_d = 3'd0;
          k_d     = k_q + 2'd1;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mat_q   <= 72'd0;
      size_q  <= 1'b0;
      k_q     <= 2'd0;
      phase_q <= 3'd0;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      minor_q <= 8'd0;
      t_q     <= 8'd0;
      acc_q   <= 8'd0;
      res_q   <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      size_q  <= size_d;
      k_q     <= k_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      minor_q <= minor_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy          = (state_q == ST_CALC);
  assign done          = (state_q == ST_DONE);
  assign resultado     = res_q;
  assign flag_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_det.sv
`default_nettype none
// ============================================================================
// Module : tb_mod_det
// Brief  : Randomized self-checking bench for mod_det against an integer reference model.
// Rev    : 1.0
// ============================================================================
module tb_mod_det;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        tamanho;
  logic [71:0] matriz_in;
  logic        busy;
  logic        done;
  logic [7:0]  resultado;
  logic        flag_overflow;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  prev_res;

  mod_det dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .tamanho       (tamanho),
    .matriz_in     (matriz_in),
    .busy          (busy),
    .done          (done),
    .resultado     (resultado),
    .flag_overflow (flag_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int wrap8(input int v);
    int w;
    w = v & 255;
    if (w > 127) w -= 256;
    return w;
  endfunction

  function automatic int mulw(input int a, input int b, output bit o);
    int p;
    p = a * b;
    o = (p > 127) || (p < -128);
    return wrap8(p);
  endfunction

  function automatic int addw(input int a, input int b, output bit o);
    int s;
    s = a + b;
    o = (s > 127) || (s < -128);
    return wrap8(s);
  endfunction

  // Determinant by cofactor expansion along row 0, each step wrapped to 8 bits.
  function automatic void ref_det(input logic [71:0] m, input bit sz, output int res, output bit ovf);
    int e[3][3];
    int a, b, c, d, x, y, mn, t, acc;
    bit o;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        e[i][j] = int'($signed(m[8*(3*i+j) +: 8]));
    ovf = 1'b0;
    if (!sz) begin
      x = mulw(e[0][0], e[1][1], o); ovf |= o;
      y = mulw(e[0][1], e[1][0], o); ovf |= o;
      res = addw(x, -y, o);          ovf |= o;
    end else begin
      acc = 0;
      for (int k = 0; k < 3; k++) begin
        case (k)
          0:       begin a = e[1][1]; d = e[2][2]; b = e[1][2]; c = e[2][1]; end
          1:       begin a = e[1][0]; d = e[2][2]; b = e[1][2]; c = e[2][0]; end
          default: begin a = e[1][0]; d = e[2][1]; b = e[1][1]; c = e[2][0]; end
        endcase
        x  = mulw(a, d, o);        ovf |= o;
        y  = mulw(b, c, o);        ovf |= o;
        mn = addw(x, -y, o);       ovf |= o;
        t  = mulw(e[0][k], mn, o); ovf |= o;
        acc = addw(acc, (k == 1) ? -t : t, o); ovf |= o;
      end
      res = acc;
    end
  endfunction

  function automatic logic [71:0] pack9(input int v[9]);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[8*i +: 8] = v[i][7:0];
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [71:0] m, input bit sz);
    int er, lat, cnt;
    bit eo, seen;
    ref_det(m, sz, er, eo);
    lat = sz ? 16 : 4;
    @(negedge clk);
    matriz_in = m;
    tamanho   = sz;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    matriz_in = {8'($urandom), 32'($urandom), 32'($urandom)};
    tamanho   = 1'($urandom);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        chk_eq({tag, "_busy"}, busy, 1);
        chk_eq({tag, "_hold"}, resultado, prev_res);
        chk_eq({tag, "_ovfclr"}, flag_overflow, 0);
      end
      if (done) seen = 1'b1;
    end
    chk_eq({tag, "_lat"}, cnt, lat);
    chk_eq({tag, "_donebusy"}, busy, 0);
    chk_eq({tag, "_res"}, resultado, er[7:0]);
    chk_eq({tag, "_ovf"}, flag_overflow, eo);
    prev_res = er[7:0];
    @(negedge clk);
    chk_eq({tag, "_pulse"}, done, 0);
    chk_eq({tag, "_keep"}, resultado, prev_res);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int vals[9];
    logic [71:0] m;
    int er, last, ndone;
    bit eo, dseen;

    rst       = 1'b1;
    start     = 1'b1;
    tamanho   = 1'b0;
    matriz_in = '1;
    prev_res  = 8'd0;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_res", resultado, 0);
    chk_eq("rst_ovf", flag_overflow, 0);
    rst   = 1'b0;
    start = 1'b0;

    vals = '{5, 3, 0, 2, 4, 0, 0, 0, 0};      run_op("d2a", pack9(vals), 1'b0);
    vals = '{10, -2, 0, 3, 1, 0, 0, 0, 0};    run_op("d2b", pack9(vals), 1'b0);
    vals = '{2, -3, 1, 2, 0, -1, 1, 4, 5};    run_op("d3a", pack9(vals), 1'b1);
    vals = '{50, 0, 0, 0, 6, 0, 0, 0, 0};     run_op("d2ovf", pack9(vals), 1'b0);
    vals = '{1, 0, 0, 0, 1, 0, 0, 0, 0};      run_op("d2id", pack9(vals), 1'b0);

    // Abort a 3x3 run with reset after ignoring extra start pulses.
    vals = '{2, -3, 1, 2, 0, -1, 1, 4, 5};
    @(negedge clk);
    matriz_in = pack9(vals);
    tamanho   = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dseen = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
      if (c == 7) chk_eq("abort_stillbusy", busy, 1);
      if (c == 9) begin
        chk_eq("abort_nodone", dseen, 0);
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_res", resultado, 0);
        chk_eq("abort_ovf", flag_overflow, 0);
        rst = 1'b0;
      end
      start = (c >= 2 && c <= 6);
      if (c == 8) rst = 1'b1;
    end
    prev_res = 8'd0;
    run_op("after_abort", pack9(vals), 1'b1);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 9; i++)
        vals[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) - 128
                                              : int'($urandom_range(0, 10)) - 5;
      m = pack9(vals);
      run_op($sformatf("rnd%0d", n), m, 1'($urandom));
    end

    // Start held high: back-to-back 2x2 operations.
    vals = '{5, 3, 0, 2, 4, 0, 0, 0, 0};
    m = pack9(vals);
    ref_det(m, 1'b0, er, eo);
    @(negedge clk);
    matriz_in = m;
    tamanho   = 1'b0;
    start     = 1'b1;
    last  = -1;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        chk_eq("held_busy", busy, 0);
        chk_eq("held_res", resultado, er[7:0]);
        if (last >= 0) chk_eq("held_gap", c - last, 5);
        last = c;
        ndone++;
      end
    end
    start = 1'b0;
    chk_eq("held_count", ndone, 8);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
